// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a song memory and holds each note's half-period on freq for its duration.
// Optional feature: define PAUSE_EN to add a `pause` input that freezes the current note.
module melody_sequencer #(
    parameter int TICK_CYCLES = 2500000,
    parameter int GAP_TICKS   = 1,
    parameter int SONG_LEN    = 64,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
`ifdef PAUSE_EN
    input  logic              pause,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [31:0]       freq,
    output logic              tone_en,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int                PW         = $clog2(TICK_CYCLES + 1);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]        GAP_LAST   = 4'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [19:0]       freq_q, freq_d;
    logic              tone_q, tone_d;
    logic [3:0]        dur_q, dur_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [3:0]        tick_q, tick_d;
    logic              done_q, done_d;
    logic              step_next;
    logic              song_end;
    logic              frozen;

`ifdef PAUSE_EN
    assign frozen = pause;
`else
    assign frozen = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            freq_q  <= '0;
            tone_q  <= 1'b0;
            dur_q   <= '0;
            presc_q <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            freq_q  <= freq_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // start is a single-cycle request honoured only in IDLE; stop is a level that overrides everything.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        freq_d    = freq_q;
        tone_d    = tone_q;
        dur_d     = dur_q;
        presc_d   = presc_q;
        tick_d    = tick_q;
        done_d    = 1'b0;
        step_next = 1'b0;
        song_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (rom_data[23:20] == 4'd0) begin
                    song_end = 1'b1;
                end else begin
                    state_d = S_PLAY;
                    freq_d  = rom_data[19:0];
                    tone_d  = (rom_data[19:0] != 20'd0);
                    dur_d   = rom_data[23:20];
                    presc_d = '0;
                    tick_d  = '0;
                end
            end
            S_PLAY: begin
                if (!frozen) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = tick_q + 4'd1;
                        if (tick_q == dur_q - 4'd1) begin
                            if (GAP_TICKS > 0) begin
                                state_d = S_GAP;
                                tone_d  = 1'b0;
                                tick_d  = '0;
                            end else begin
                                step_next = 1'b1;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            S_GAP: begin
                if (!frozen) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = tick_q + 4'd1;
                        if (tick_q == GAP_LAST) begin
                            step_next = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Advance to the next entry unless the last addressable entry was just played.
        if (step_next) begin
            if (addr_q == LAST_ADDR) begin
                song_end = 1'b1;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end

        if (song_end) begin
            if (loop_en) begin
                addr_d  = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                freq_d  = '0;
                tone_d  = 1'b0;
            end
        end

        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            freq_d  = '0;
            tone_d  = 1'b0;
            presc_d = '0;
            tick_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        rom_addr  = addr_q;
        freq      = {12'b0, freq_q};
        busy      = (state_q != S_IDLE);
        done      = done_q;
        state_dbg = state_q;
        // Pause silences the divider without losing the note's own tone value.
        tone_en   = tone_q & ~(frozen & ((state_q == S_PLAY) | (state_q == S_GAP)));
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: randomized and directed songs checked cycle-by-cycle against a timeline model.
// Define PAUSE_EN to also exercise the pause input.
module tb_melody_sequencer;

  localparam int TC = 4;
  localparam int GP = 1;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic        pause;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [31:0] freq;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  logic [23:0] mem [0:SL-1];

  // {addr, freq, tone_en, busy, done} expected for each cycle after the start edge
  logic [42:0] exp_q[$];
  logic        lp_q[$];

  int vectors = 0;
  int errors  = 0;

  melody_sequencer #(
    .TICK_CYCLES(TC),
    .GAP_TICKS  (GP),
    .SONG_LEN   (SL),
    .ADDR_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
`ifdef PAUSE_EN
    .pause    (pause),
`endif
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .freq     (freq),
    .tone_en  (tone_en),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr[1:0]];

  task automatic check(input string tag, input logic [42:0] exp);
    logic [42:0] got;
    got = {rom_addr, freq, tone_en, busy, done};
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: addr/freq/tone/busy/done got %0h/%0h/%b/%b/%b required %0h/%0h/%b/%b/%b",
             tag, got[42:35], got[34:3], got[2], got[1], got[0],
             exp[42:35], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input int addr, input logic [19:0] f, input logic t,
                      input logic b, input logic d);
    exp_q.push_back({8'(addr), {12'b0, f}, t, b, d});
    lp_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Timeline of a song from its note list: FETCH, LOAD, dur*TC sounding, GP*TC silent, next entry.
  task automatic gen_trace(input int passes);
    int          addr;
    int          d;
    int          pass;
    bit          fin;
    bit          end_now;
    logic [19:0] f;
    logic        t;
    exp_q.delete();
    lp_q.delete();
    addr = 0; pass = 0; fin = 0; f = '0; t = 1'b0;
    while (!fin) begin
      push(addr, f, t, 1'b1, 1'b0);
      push(addr, f, t, 1'b1, 1'b0);
      d = int'(mem[addr][23:20]);
      if (d != 0) begin
        f = mem[addr][19:0];
        t = (f != 20'd0);
        repeat (d * TC) push(addr, f, t, 1'b1, 1'b0);
        if (GP > 0) begin
          t = 1'b0;
          repeat (GP * TC) push(addr, f, t, 1'b1, 1'b0);
        end
      end
      end_now = (d == 0) || (addr == SL - 1);
      if (!end_now) begin
        addr++;
      end else if (pass < passes - 1) begin
        lp_q[lp_q.size() - 1] = 1'b1;
        pass++;
        addr = 0;
      end else begin
        lp_q[lp_q.size() - 1] = 1'b0;
        f = '0;
        t = 1'b0;
        push(addr, f, t, 1'b0, 1'b1);
        push(addr, f, t, 1'b0, 1'b0);
        fin = 1;
      end
    end
  endtask

  // driver: start pulse, then follow the timeline; abort_kind 1 = stop, 2 = reset at abort_at
  task automatic run_trace(input string name, input int abort_kind, input int abort_at);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_c%0d", name, i), exp_q[i]);
      loop_en = lp_q[i];
      start = exp_q[i][1] ? 1'($urandom_range(0, 1)) : 1'b0;
      if (abort_kind != 0 && i == abort_at) begin
        if (abort_kind == 1) stop = 1'b1;
        else rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          start = 1'b0;
          check($sformatf("%s_abort%0d", name, k), 43'd0);
        end
        stop = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s_after", name), 43'd0);
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int passes;
    int abort_kind;
    int abort_at;
    rst = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; pause = 1'b0;
    for (int k = 0; k < SL; k++) mem[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 43'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_release", 43'd0);

    // single note then end marker
    mem[0] = {4'd3, 20'h001F4}; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    gen_trace(1);
    run_trace("single", 0, 0);

    // rest entry
    mem[0] = {4'd2, 20'h00000}; mem[1] = '0;
    gen_trace(1);
    run_trace("rest", 0, 0);

    // full-length song looping three times, no end marker
    mem[0] = {4'd1, 20'h00010}; mem[1] = {4'd1, 20'h00020};
    mem[2] = {4'd1, 20'h00030}; mem[3] = {4'd1, 20'hFFFFF};
    gen_trace(3);
    run_trace("loop", 0, 0);

    // stop at the fifth PLAY cycle
    mem[0] = {4'd6, 20'h00123}; mem[1] = '0;
    gen_trace(1);
    run_trace("stop", 1, 6);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("collide", 43'd0);
    @(posedge clk); #1;
    check("collide_idle", 43'd0);

    // reset held mid-PLAY
    mem[0] = {4'd5, 20'h0ABCD};
    gen_trace(1);
    run_trace("rst_mid", 2, 8);

    // randomized songs
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < SL; k++)
        mem[k] = {4'($urandom_range(0, 4)),
                  ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom)};
      passes = $urandom_range(1, 3);
      gen_trace(passes);
      abort_kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      abort_at = $urandom_range(0, exp_q.size() - 3);
      run_trace($sformatf("rnd%0d", r), abort_kind, abort_at);
    end

`ifdef PAUSE_EN
    begin
      int hi;
      int dn;
      hi = 0; dn = 0;
      mem[0] = {4'd2, 20'h00100}; mem[1] = '0;
      loop_en = 1'b0;
      start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        #1;
        pause = (i >= 5 && i < 15);
        #1;
        if (pause) begin
          vectors++;
          assert (tone_en === 1'b0) else begin
            errors++;
            $error("FAIL pause_tone_c%0d: got %b required 0", i, tone_en);
          end
        end
        if (tone_en) hi++;
        if (done) dn++;
        @(posedge clk);
      end
      pause = 1'b0;
      #1;
      vectors++;
      assert (hi === 8) else begin
        errors++;
        $error("FAIL pause_total: got %0d required 8", hi);
      end
      vectors++;
      assert (dn === 1) else begin
        errors++;
        $error("FAIL pause_done: got %0d required 1", dn);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Upstream stage of the tone divider. Steps through an external song memory of note entries and presents each entry's half-period count on `freq`, holding it for the note's duration. Between notes it inserts a short silence gap. `tone_en` gates the divider (wired to the divider's active-low reset), so the divider only toggles while a note sounds.

Parameters:
TICK_CYCLES, 2500000, clk cycles per duration tick (50 ms at 50 MHz); must be >= 1
GAP_TICKS, 1, silent ticks inserted after every note; 0 = no gap
SONG_LEN, 64, max entries played; addresses 0..SONG_LEN-1; <= 256
ADDR_W, 8, width of rom_addr

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
start  input  1  1-cycle pulse; begin playback at address 0 (ignored when busy)
stop  input  1  abort playback; return to IDLE
loop_en  input  1  sampled at end of song; 1 = restart at address 0
rom_addr  output  ADDR_W  registered song-memory address
rom_data  input  24  entry; [23:20] duration ticks, [19:0] half-period count; valid 1 cycle after rom_addr changes
freq  output  32  half-period count for the divider, zero-extended from rom_data[19:0]
tone_en  output  1  1 while a non-rest note is sounding
busy  output  1  1 in any state except IDLE
done  output  1  1-cycle pulse on natural end of song (not on stop)

Behaviour:
- Reset (rst=0 at a clk edge), values on the following cycle:
  - state=IDLE, rom_addr=0, freq=0, tone_en=0, busy=0, done=0.
  - Tick prescaler and tick counter are 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE:
  - start=1 and stop=0 -> FETCH, rom_addr=0, busy=1.
  - start with stop in the same cycle: stop wins; remain IDLE.
- FETCH: one wait cycle for memory latency -> LOAD.
- LOAD: capture rom_data.
  - duration==0: end-of-song marker; go to END handling.
  - Otherwise -> PLAY next cycle.
    - freq <= {12'b0, rom_data[19:0]}.
    - tone_en <= (rom_data[19:0] != 0); a zero half-period is a rest.
    - Prescaler and tick counter cleared.
- PLAY:
  - Prescaler counts 0..TICK_CYCLES-1; on wrap, tick counter increments.
  - When tick counter reaches the duration, exit PLAY. Total time in PLAY = duration*TICK_CYCLES cycles exactly.
  - If GAP_TICKS>0 -> GAP with tone_en=0, freq held, counters cleared.
  - Otherwise go to NEXT handling.
- GAP: GAP_TICKS*TICK_CYCLES cycles with tone_en=0, then NEXT handling.
- NEXT handling:
  - If rom_addr==SONG_LEN-1, go to END handling.
  - Otherwise rom_addr <= rom_addr+1 and -> FETCH.
- END handling:
  - loop_en=1: rom_addr <= 0, -> FETCH; done not pulsed.
  - loop_en=0: -> IDLE, done=1 for one cycle, freq=0, tone_en=0, busy=0.
- Counter widths:
  - Prescaler is $clog2(TICK_CYCLES+1) bits.
  - Tick counter is 4 bits; the GAP count must fit, so GAP_TICKS <= 15.
  - No wrap-around of rom_addr beyond SONG_LEN-1.
- stop=1 in any busy state: next cycle IDLE, freq=0, tone_en=0, rom_addr=0, busy=0, done=0. stop has priority over all transitions.
- start while busy: ignored.
- Reset mid-note: same as the reset values; no done pulse.
- Note-to-note latency with GAP_TICKS=0: last PLAY cycle -> FETCH -> LOAD -> new freq. The old freq and tone_en are held through FETCH/LOAD (2 cycles).

Optional Feature:
PAUSE_EN
- Macro defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in PLAY or GAP, the prescaler and tick counter freeze, tone_en is forced 0, and freq is held.
  - On release, the note resumes with its remaining duration and tone_en returns to its note value.
  - pause has no effect in IDLE/FETCH/LOAD; stop overrides pause.
- Macro undefined: no `pause` port; counters never freeze.

Test Plan:
- Reset sweep: hold rst=0 mid-PLAY for 3 cycles -> freq=0, tone_en=0, busy=0, rom_addr=0, done never asserted.
- Single note (TICK_CYCLES=4, GAP_TICKS=1): entry0 = dur 3, half-period 0x1F4, entry1 = dur 0; start pulse ->
  - rom_addr=0 for FETCH/LOAD, then freq=500 with tone_en=1 for exactly 12 cycles.
  - Then tone_en=0 for 4 cycles.
  - Then FETCH addr 1, LOAD, and done pulses 1 cycle with busy falling.
- Rest entry: dur 2, half-period 0 -> freq=0, tone_en=0 for 8 cycles, busy=1 throughout.
- Loop: SONG_LEN=2, both entries dur 1, loop_en=1 -> rom_addr sequence 0,1,0,1,...; no done pulse. Drop loop_en during entry 1 -> done after entry 1 ends.
- Stop mid-note plus start/stop collision: stop at PLAY cycle 5 -> IDLE next cycle, tone_en=0, no done. start and stop in the same IDLE cycle -> remains IDLE, busy=0.
- PAUSE_EN: dur 2, TICK_CYCLES=4; pause high for 10 cycles after PLAY cycle 3 -> tone_en=0 during pause; total tone_en-high cycles still 8.
